multi_pipe: RTL and testbench

MULTI_PIPE -- requirements
Module: multi_pipe

---
 rtl/multi_pipe_pkg.sv | 20 ++
 rtl/multi_pipe_stage.sv | 37 +++
 rtl/multi_pipe.sv | 90 +++++++++
 tb/tb_multi_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_pipe_pkg.sv
// Shared constants and helpers for multi_pipe: legal parameter ranges,
// fill-counter width and the default reset image (stage 0 = 1, rest 0).
package multi_pipe_pkg;

    localparam int LN_MIN        = 2;
    localparam int LN_MAX        = 64;
    localparam int W_MIN         = 1;
    localparam int W_MAX         = 64;
    localparam int FILL_MAX_BITS = W_MAX * LN_MAX;

    function automatic int fill_width(input int ln);
        return $clog2(ln + 1);
    endfunction

    // Sized for the largest legal pipe; callers cast down to W*LN.
    function automatic logic [FILL_MAX_BITS-1:0] default_fill();
        return FILL_MAX_BITS'(1);
    endfunction

endpackage

// File: rtl/multi_pipe_stage.sv
// One pipeline stage: W-bit data register plus valid bit, load beats shift.
// Latency 1 edge; holds when neither i_load nor i_en is asserted.
module pipe_stage #(
    parameter int            W    = 1,
    parameter logic [W-1:0]  INIT = '0
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_load_data,
    input  logic [W-1:0] i_shift_data,
    input  logic         i_shift_valid,
    output logic [W-1:0] o_data,
    output logic         o_valid
);

    logic [W-1:0] r_data;
    logic         r_valid;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_data  <= INIT;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_load_data;
            r_valid <= 1'b1;
        end else if (i_en) begin
            r_data  <= i_shift_data;
            r_valid <= i_shift_valid;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/multi_pipe.sv
// LN-stage shift pipe with valid bits, parallel load and fill count; LN enabled edges in->out.
// i_ce low holds everything; MULTI_PIPE_TAPS_EN exposes all stage data/valid as o_taps/o_tap_valid.
module multi_pipe
    import multi_pipe_pkg::*;
#(
    parameter int                LN           = 8,
    parameter int                W            = 1,
    parameter logic [W*LN-1:0]   INITIAL_FILL = (W*LN)'(default_fill())
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_ce,
    input  logic [W-1:0]                  i_in,
    input  logic                          i_in_valid,
    input  logic                          i_load,
    input  logic [W*LN-1:0]               i_load_data,
    output logic [W-1:0]                  o_data,
    output logic                          o_valid,
    output logic [fill_width(LN)-1:0]     o_fill,
    output logic                          o_full,
    output logic                          o_empty
`ifdef MULTI_PIPE_TAPS_EN
    ,
    output logic [W*LN-1:0]               o_taps,
    output logic [LN-1:0]                 o_tap_valid
`endif
);

    localparam int FW = fill_width(LN);

    if (LN < LN_MIN || LN > LN_MAX || W < W_MIN || W > W_MAX) begin : g_bad_params
        $error("multi_pipe: LN must be 2..64 and W must be 1..64");
    end

    logic [W*LN-1:0] w_stage_data;
    logic [LN-1:0]   w_stage_vld;
    logic [FW-1:0]   r_fill;

    for (genvar k = 0; k < LN; k++) begin : g_stage
        logic [W-1:0] w_next_data;
        logic         w_next_vld;

        // The last stage is fed from the input port; the rest from their upstream neighbour.
        if (k == LN - 1) begin : g_tail
            assign w_next_data = i_in;
            assign w_next_vld  = i_in_valid;
        end else begin : g_body
            assign w_next_data = w_stage_data[W*(k+1) +: W];
            assign w_next_vld  = w_stage_vld[k+1];
        end

        pipe_stage #(
            .W    (W),
            .INIT (INITIAL_FILL[W*k +: W])
        ) u_stage (
            .i_clk         (i_clk),
            .i_reset_n     (i_reset_n),
            .i_en          (i_ce),
            .i_load        (i_load),
            .i_load_data   (i_load_data[W*k +: W]),
            .i_shift_data  (w_next_data),
            .i_shift_valid (w_next_vld),
            .o_data        (w_stage_data[W*k +: W]),
            .o_valid       (w_stage_vld[k])
        );
    end

    // Counter tracks popcount of valid bits incrementally; bounded by construction.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_fill <= '0;
        end else if (i_load) begin
            r_fill <= FW'(LN);
        end else if (i_ce) begin
            r_fill <= r_fill + FW'(i_in_valid) - FW'(w_stage_vld[0]);
        end
    end

    assign o_data  = w_stage_data[W-1:0];
    assign o_valid = w_stage_vld[0];
    assign o_fill  = r_fill;
    assign o_full  = (r_fill == FW'(LN));
    assign o_empty = (r_fill == '0);

`ifdef MULTI_PIPE_TAPS_EN
    assign o_taps      = w_stage_data;
    assign o_tap_valid = w_stage_vld;
`endif

endmodule

// File: tb/tb_multi_pipe.sv
module tb_multi_pipe;

    localparam int W  = 8;
    localparam int LN = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ce;
    logic [W-1:0]    in_d;
    logic            in_vld;
    logic            load;
    logic [W*LN-1:0] load_data;
    logic [W-1:0]    o_data;
    logic            o_valid;
    logic [2:0]      o_fill;
    logic            o_full;
    logic            o_empty;
`ifdef MULTI_PIPE_TAPS_EN
    logic [W*LN-1:0] o_taps;
    logic [LN-1:0]   o_tap_valid;
`endif

    multi_pipe #(.LN(LN), .W(W)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_ce        (ce),
        .i_in        (in_d),
        .i_in_valid  (in_vld),
        .i_load      (load),
        .i_load_data (load_data),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_fill      (o_fill),
        .o_full      (o_full),
        .o_empty     (o_empty)
`ifdef MULTI_PIPE_TAPS_EN
        ,
        .o_taps      (o_taps),
        .o_tap_valid (o_tap_valid)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: an array of LN slots, slot 0 is the output end.
    logic [W-1:0] m_data [LN];
    logic         m_vld  [LN];

    function automatic int m_fill();
        int n = 0;
        for (int k = 0; k < LN; k++) n += int'(m_vld[k]);
        return n;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < LN; k++) begin
            m_data[k] = '0;
            m_vld[k]  = 1'b0;
        end
        m_data[0] = 8'h01;
    endtask

    // Advance the model with the current inputs, then let the DUT take the same edge.
    task automatic cycle();
        if (load) begin
            for (int k = 0; k < LN; k++) begin
                m_data[k] = load_data[W*k +: W];
                m_vld[k]  = 1'b1;
            end
        end else if (ce) begin
            for (int k = 0; k < LN - 1; k++) begin
                m_data[k] = m_data[k+1];
                m_vld[k]  = m_vld[k+1];
            end
            m_data[LN-1] = in_d;
            m_vld[LN-1]  = in_vld;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        ce = 0; in_d = '0; in_vld = 0; load = 0; load_data = '0;
        rst_n = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (o_data !== 8'h01) begin errors++; $display("FAIL reset_data got %h want 01", o_data); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
        checks++; if (o_fill !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d want 0", o_fill); end
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", o_empty); end
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", o_full); end
    endtask

    task automatic test_fill();
        ce = 1; in_vld = 1;
        for (int i = 0; i < 4; i++) begin
            in_d = 8'(8'h11 * (i + 1));
            cycle();
            checks++;
            if (o_fill !== 3'(i + 1)) begin errors++; $display("FAIL fill_step%0d got %0d want %0d", i, o_fill, i + 1); end
        end
        checks++; if (o_data !== 8'h11) begin errors++; $display("FAIL fill_data got %h want 11", o_data); end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL fill_valid got %b want 1", o_valid); end
        checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", o_full); end
    endtask

    task automatic test_drain();
        logic [7:0] exp_d [4];
        exp_d = '{8'h22, 8'h33, 8'h44, 8'h44};
        ce = 1; in_vld = 0; in_d = 8'h44;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (o_fill !== 3'(3 - i)) begin errors++; $display("FAIL drain_fill%0d got %0d want %0d", i, o_fill, 3 - i); end
            checks++;
            if (o_data !== exp_d[i]) begin errors++; $display("FAIL drain_data%0d got %h want %h", i, o_data, exp_d[i]); end
        end
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", o_empty); end
    endtask

    task automatic test_load();
        load = 1; ce = 1; in_d = 8'h99; in_vld = 1; load_data = 32'hDDCC_BBAA;
        cycle();
        load = 0;
        checks++; if (o_data !== 8'hAA) begin errors++; $display("FAIL load_data got %h want aa", o_data); end
        checks++; if (o_fill !== 3'd4) begin errors++; $display("FAIL load_fill got %0d want 4", o_fill); end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL load_valid got %b want 1", o_valid); end
        in_vld = 0;
        cycle();
        checks++; if (o_data !== 8'hBB) begin errors++; $display("FAIL load_shift_data got %h want bb", o_data); end
        checks++; if (o_fill !== 3'd3) begin errors++; $display("FAIL load_shift_fill got %0d want 3", o_fill); end
    endtask

    task automatic test_ce_hold();
        logic       ce_seq  [4];
        logic [2:0] exp_fill[4];
        ce_seq   = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_fill = '{3'd1, 3'd1, 3'd1, 3'd2};
        apply_reset();
        in_vld = 1;
        for (int i = 0; i < 4; i++) begin
            ce   = ce_seq[i];
            in_d = 8'(8'h51 + i);
            cycle();
            checks++;
            if (o_fill !== exp_fill[i]) begin errors++; $display("FAIL ce_fill%0d got %0d want %0d", i, o_fill, exp_fill[i]); end
            checks++;
            if (o_data !== m_data[0]) begin errors++; $display("FAIL ce_data%0d got %h want %h", i, o_data, m_data[0]); end
        end
    endtask

    task automatic test_async_reset();
        load = 1; load_data = 32'hDDCC_BBAA;
        cycle();
        load = 0; ce = 1; in_vld = 1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (o_data !== 8'h01) begin errors++; $display("FAIL areset_data got %h want 01", o_data); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", o_valid); end
        checks++; if (o_fill !== 3'd0) begin errors++; $display("FAIL areset_fill got %0d want 0", o_fill); end
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL areset_empty got %b want 1", o_empty); end
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL areset_full got %b want 0", o_full); end
        // A load strobe during reset must be discarded.
        load = 1;
        @(posedge clk);
        #1;
        checks++; if (o_fill !== 3'd0) begin errors++; $display("FAIL areset_load_fill got %0d want 0", o_fill); end
        load = 0;
        rst_n = 1'b1;
        m_reset();
        ce = 1; in_vld = 1; in_d = 8'h5A;
        cycle();
        checks++; if (o_fill !== 3'd1) begin errors++; $display("FAIL post_reset_fill got %0d want 1", o_fill); end
        in_vld = 0;
        for (int i = 0; i < 3; i++) cycle();
        checks++; if (o_data !== 8'h5A) begin errors++; $display("FAIL post_reset_data got %h want 5a", o_data); end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL post_reset_valid got %b want 1", o_valid); end
    endtask

    task automatic test_random();
        int f;
        apply_reset();
        for (int n = 0; n < 10000; n++) begin
            ce        = ($urandom_range(0, 3) != 0);
            in_vld    = 1'($urandom);
            load      = ($urandom_range(0, 15) == 0);
            in_d      = 8'($urandom);
            load_data = $urandom;
            cycle();
            f = m_fill();
            checks++;
            if (o_fill !== 3'(f)) begin errors++; $display("FAIL rnd_fill cyc %0d got %0d want %0d", n, o_fill, f); end
            checks++;
            if (o_data !== m_data[0] || o_valid !== m_vld[0]) begin
                errors++;
                $display("FAIL rnd_out cyc %0d got %h/%b want %h/%b", n, o_data, o_valid, m_data[0], m_vld[0]);
            end
            checks++;
            if (o_full !== (f == LN) || o_empty !== (f == 0)) begin
                errors++;
                $display("FAIL rnd_flags cyc %0d got full %b empty %b fill_ref %0d", n, o_full, o_empty, f);
            end
`ifdef MULTI_PIPE_TAPS_EN
            begin
                logic [W*LN-1:0] et;
                logic [LN-1:0]   ev;
                for (int k = 0; k < LN; k++) begin
                    et[W*k +: W] = m_data[k];
                    ev[k]        = m_vld[k];
                end
                checks++;
                if (o_taps !== et || o_tap_valid !== ev) begin
                    errors++;
                    $display("FAIL rnd_taps cyc %0d got %h/%b want %h/%b", n, o_taps, o_tap_valid, et, ev);
                end
            end
`endif
        end
        load = 0; ce = 0;
    endtask

    initial begin
        rst_n = 1'b0; ce = 0; in_d = '0; in_vld = 0; load = 0; load_data = '0;
        #2;
        test_reset();
        test_fill();
        test_drain();
        test_load();
        test_ce_hold();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
